// File: rtl/dac_sample_sender.sv
// dac_sample_sender: buffers filtered samples in a small FIFO and serializes them as an I2S stream
// (BCLK, DACLRCK, DACDAT) derived from the system clock. Optional macro: DAC_SENDER_MONO_DUP_EN.
module dac_sample_sender #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_LOG2  = 2,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    output logic                  overflow,
    output logic                  underrun,
    output logic                  bclk,
    output logic                  daclrck,
    output logic                  dacdat
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int CW    = FIFO_LOG2 + 1;
    localparam int DIV_W = $clog2(BCLK_DIV);

    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0]     DIV_ONE  = DIV_W'(1);
    localparam logic [CW-1:0]        CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [FIFO_LOG2-1:0] PTR_ONE  = FIFO_LOG2'(1);
    localparam logic [4:0]           LAST_BIT = 5'(DATA_WIDTH);

    typedef enum logic {
        ST_WAIT,
        ST_RUN
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W-1:0]      div_q;
    logic                  bclk_q;
    logic [5:0]            bit_cnt_q;
    logic [5:0]            entry_idx;
    logic                  bclk_fall;
    logic                  slot_start;
    logic                  pop_req;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_LOG2-1:0]  rd_ptr_q;
    logic [FIFO_LOG2-1:0]  wr_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] load_val;

    logic [DATA_WIDTH-1:0] shreg_q;
    logic                  dacdat_q;
    logic                  overflow_q;
    logic                  underrun_q;
`ifdef DAC_SENDER_MONO_DUP_EN
    logic [DATA_WIDTH-1:0] sample_q;
`endif

    // ------------------------------------------------------------------
    // BCLK divider
    // ------------------------------------------------------------------
    assign bclk_fall = bclk_q && (div_q == DIV_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q  <= '0;
            bclk_q <= ~bclk_q;
        end else begin
            div_q <= div_q + DIV_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer: the first falling edge after reset enters bit 0
    // without advancing the counter; afterwards every fall advances it.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        entry_idx = 6'd0;
        case (state_q)
            ST_WAIT: begin
                if (bclk_fall) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                entry_idx = bit_cnt_q + 6'd1;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    assign slot_start = bclk_fall && (entry_idx[4:0] == 5'd0);

`ifdef DAC_SENDER_MONO_DUP_EN
    assign pop_req = slot_start && !entry_idx[5];
`else
    assign pop_req = slot_start;
`endif

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign pop      = pop_req && !empty;
    assign push     = write && (!full || pop);
    assign drop     = write && !push;
    assign head     = mem[rd_ptr_q];
    assign load_val = pop ? head : '0;

    // A full FIFO popped and pushed in one cycle reads the old head before the slot is overwritten.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            overflow_q <= drop;
            underrun_q <= pop_req && empty;
        end
    end

    // ------------------------------------------------------------------
    // Serializer: bit 0 of each slot is the I2S one-bit delay, then the
    // sample MSB first, then zero padding to the end of the slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            dacdat_q  <= 1'b0;
`ifdef DAC_SENDER_MONO_DUP_EN
            sample_q  <= '0;
`endif
        end else if (bclk_fall) begin
            bit_cnt_q <= entry_idx;
            if (entry_idx[4:0] == 5'd0) begin
                dacdat_q <= 1'b0;
`ifdef DAC_SENDER_MONO_DUP_EN
                if (pop_req) begin
                    shreg_q  <= load_val;
                    sample_q <= load_val;
                end else begin
                    shreg_q <= sample_q;
                end
`else
                shreg_q <= load_val;
`endif
            end else if (entry_idx[4:0] <= LAST_BIT) begin
                dacdat_q <= shreg_q[DATA_WIDTH-1];
                shreg_q  <= shreg_q << 1;
            end else begin
                dacdat_q <= 1'b0;
            end
        end
    end

    assign bclk     = bclk_q;
    assign daclrck  = bit_cnt_q[5];
    assign dacdat   = dacdat_q;
    assign overflow = overflow_q;
    assign underrun = underrun_q;

endmodule

// File: doc/dac_sample_sender.md
# dac_sample_sender

Output end of the audio effects chain. Accepts filtered samples on the same one-cycle `write` strobe + data protocol the effect blocks emit (`done`/`sum`), buffers them in a small FIFO, and serializes them to the codec DAC as an I2S stream (BCLK, DACLRCK, DACDAT) generated from the system clock. Sits between the last effect stage and the DE1 audio codec pins.

## Interface
- `DATA_WIDTH`, 16, sample width in bits, two's complement; legal range 8..31.
- `FIFO_LOG2`, 2, FIFO depth is 2**FIFO_LOG2 entries.
- `BCLK_DIV`, 4, system clocks per BCLK half-period; legal range ≥ 2.
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `write`  in  1  one-cycle strobe; `data_in` is valid in that cycle.
- `data_in`  in  DATA_WIDTH  sample to enqueue.
- `full`  out  1  FIFO holds 2**FIFO_LOG2 entries.
- `overflow`  out  1  one-cycle pulse when a write is dropped.
- `underrun`  out  1  one-cycle pulse when a pop finds the FIFO empty.
- `bclk`  out  1  codec bit clock.
- `daclrck`  out  1  codec L/R clock; 0 selects the left slot, 1 the right.
- `dacdat`  out  1  codec serial data.

## Operation
- Reset: all outputs 0, FIFO empty, divider and bit counter 0, shift register 0. Reset may assert at any time, including mid-frame; outputs go to 0 immediately.
- Divider counts 0..BCLK_DIV-1; on wrap `bclk` toggles. BCLK period is 2*BCLK_DIV clocks.
- Bit counter 0..63 advances on every BCLK falling edge. Frame = 64 BCLK periods; slot = 32 periods.
- `daclrck`, `dacdat` and the bit counter change only on BCLK falling edges. `daclrck` = bit counter[5].
- I2S alignment: at slot bit 0, `dacdat` = 0 (one-bit delay). At slot bits 1..DATA_WIDTH, `dacdat` carries the sample MSB first. At slot bits DATA_WIDTH+1..31, `dacdat` = 0.
- Pop: happens on the falling edge that enters a slot's bit 0 when a new sample is due. If the FIFO is non-empty, the head is loaded into the shift register. If it is empty, the shift register loads 0 and `underrun` pulses.
- Write: when `write`=1 and the FIFO is not full, or it is full and a pop occurs in the same cycle, the sample is enqueued. Otherwise the sample is dropped and `overflow` pulses.
- A sample written in cycle N is eligible for a pop in cycle N+1 or later.
- Occupancy counter is exact under a simultaneous push and pop. Read and write pointers wrap modulo the depth.
- `full` is combinational from the registered occupancy.

## Timing
- First BCLK falling edge after reset release occurs 2*BCLK_DIV clocks later and starts frame bit 0 (left slot, first pop).
- Sample rate = clock / (128*BCLK_DIV). At 50 MHz with BCLK_DIV=4 this is 97.66 kHz.
- Latency, write to MSB on `dacdat` with an empty FIFO: up to one frame plus one BCLK period.
- `overflow` and `underrun` are high for exactly one clock per event and are never sticky.

## Configuration
- `DAC_SENDER_MONO_DUP_EN` defined: one pop per frame, at left bit 0 only. The right slot re-sends the same sample. One `underrun` per frame at most.
- Not defined: pops at both left bit 0 and right bit 0, so successive samples alternate left/right. Up to two `underrun` pulses per frame.

## Test plan
- Reset mid-frame (`reset_n`=0 at bit 20 of the right slot) -> all outputs 0 that cycle. After release, the first falling edge comes 2*BCLK_DIV clocks later with `daclrck`=0.
- DATA_WIDTH=16, BCLK_DIV=2, write 16'hA5C3 before frame start -> left slot `dacdat` bits 1..16 = 1010010111000011, bits 0 and 17..31 = 0, sampled on BCLK rising edges.
- No writes after reset -> `underrun` pulses once per frame with MONO_DUP, twice without; `dacdat` stays 0.
- FIFO_LOG2=2, five back-to-back writes while idle -> `full`=1 after the fourth, `overflow` pulses on the fifth, and the first four samples are emitted in order.
- FIFO full and a `write` in the same cycle as a pop -> no `overflow`, occupancy stays 4, and the new sample is emitted fourth after the popped one.
- Without `DAC_SENDER_MONO_DUP_EN`, write 16'h0001 then 16'h8000 -> left slot = 0001, right slot = 8000 in the same frame.
